coeff_loader: RTL and testbench
===============================

Name: coeff_loader

Overview:
- Drives the coefficient and enable side of a bank of NUM_TAPS filter taps.
- Accepts a host coefficient stream over a valid/ready handshake and fills a shadow bank.
- On a complete, well-framed load, copies the shadow bank atomically into the active bank that feeds each tap's coeff input. Taps never see a partially loaded coefficient set.
- Sits between the DSP pipeline's configuration interface and the tap array.

Parameters:
NUM_TAPS, 8, number of taps driven (>=2)
COEFF_WIDTH, 16, bits per coefficient
CNT_WIDTH, 16, width of commit_count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_load  in  1  one-cycle pulse; begins (or restarts) a load
cfg_valid  in  1  coefficient beat valid
cfg_ready  out  1  loader accepts a beat
cfg_data  in  COEFF_WIDTH  coefficient value, tap 0 first
cfg_last  in  1  marks final beat of a load
run_en  in  1  request taps to multiply
coeff_bus  out  NUM_TAPS*COEFF_WIDTH  active coefficients; tap i at [i*COEFF_WIDTH +: COEFF_WIDTH]
tap_enable  out  NUM_TAPS  per-tap enable
load_done  out  1  one-cycle pulse on commit
load_error  out  1  sticky framing error
busy  out  1  high in LOAD or COMMIT
commit_count  out  CNT_WIDTH  successful commits, wraps

Behaviour:
- Clock and reset: one clock clk; rst_n is asynchronous, active-low.
- Reset values: state IDLE; coeff_bus, shadow bank, index, tap_enable, load_done, load_error, busy, commit_count, and the internal bank_valid flag all 0; cfg_ready 0.
- States: IDLE, LOAD, COMMIT, ERROR.
- IDLE:
  - cfg_ready=0.
  - start_load -> LOAD; index<=0; load_error<=0.
- LOAD:
  - cfg_ready=1, busy=1. A beat is accepted when cfg_valid&cfg_ready.
  - Accepted beat writes shadow[index]; index<=index+1.
  - Beat at index NUM_TAPS-1 with cfg_last=1 -> COMMIT.
  - cfg_last=1 at index<NUM_TAPS-1 -> ERROR (short load).
  - Beat at index NUM_TAPS-1 with cfg_last=0 -> ERROR (long load).
  - start_load in LOAD aborts the load: index<=0, stay in LOAD, beat in that same cycle ignored. start_load has priority over a beat.
- COMMIT (exactly 1 cycle):
  - cfg_ready=0.
  - coeff_bus<=shadow; bank_valid<=1; load_done=1 in the following cycle (registered pulse).
  - commit_count<=commit_count+1, wrapping at 2^CNT_WIDTH.
  - -> IDLE. start_load during COMMIT is ignored.
- ERROR:
  - load_error=1 (registered, sticky); cfg_ready=0.
  - Active bank is untouched; shadow contents are don't-care.
  - start_load -> LOAD and clears load_error.
- tap_enable: registered, all bits = run_en & bank_valid.
  - Before the first commit, taps stay disabled (pass-through).
  - The cycle after COMMIT, tap_enable reflects the new bank and coeff_bus is already updated. Coefficients and enables never change in the same cycle except for the first enable after the first commit.
- Reset mid-load: load discarded; active bank returns to 0; bank_valid=0.
- Latency: last beat accepted at cycle N; state COMMIT at N+1; coeff_bus and load_done visible at N+2.

Decomposition:
- Shared DSP package: loader_state_t enum {LD_IDLE, LD_LOAD, LD_COMMIT, LD_ERROR} (2-bit logic) and localparam INDEX_WIDTH=$clog2(NUM_TAPS) helper.
- One natural sub-module: coeff_bank. It holds the shadow and active register arrays, plus the write port (index, data, we) and the commit strobe. The FSM, handshake, and counters stay in coeff_loader.

Test Plan:
- Reset, then 8 beats 0x0100..0x0800 with cfg_last on the 8th, run_en=1 -> load_done pulse once; coeff_bus tap i = 0x0100*(i+1); commit_count=1; tap_enable=8'hFF one cycle after commit.
- Short load: cfg_last on beat 5 -> load_error=1, cfg_ready=0, coeff_bus unchanged, commit_count unchanged; next start_load clears load_error.
- Long load: beat 8 without cfg_last -> ERROR; tap_enable unaffected by the error, stays 8'hFF if previously committed.
- cfg_valid toggling every other cycle, plus start_load after 3 beats -> index restarts; only the following 8 beats land in coeff_bus.
- run_en=1 before any commit -> tap_enable=0. Assert rst_n low mid-LOAD -> all outputs 0 asynchronously.
- Preload commit_count to 2^CNT_WIDTH-1 via repeated loads (CNT_WIDTH=2 in bench) -> the fourth commit wraps the count to 0.

Source files
------------

// File: rtl/coeff_loader_pkg.sv
// rtl/coeff_loader_pkg.sv - shared loader state encoding and index sizing helper
package coeff_loader_pkg;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_COMMIT,
        LD_ERROR
    } loader_state_t;

    function automatic int index_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/coeff_bank.sv
// rtl/coeff_bank.sv - shadow coefficient registers with atomic copy into the active bank
module coeff_bank #(
    parameter int NUM_TAPS    = 8,
    parameter int COEFF_WIDTH = 16,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            we,
    input  logic [INDEX_WIDTH-1:0]          index,
    input  logic [COEFF_WIDTH-1:0]          data,
    input  logic                            commit,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff_bus
);

    logic [COEFF_WIDTH-1:0] shadow [NUM_TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow[i] <= '0;
            end
        end else if (we) begin
            shadow[index] <= data;
        end
    end

    // The whole active bank changes on a single edge, so taps never mix old and new sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coeff_bus <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coeff_bus[i*COEFF_WIDTH +: COEFF_WIDTH] <= shadow[i];
            end
        end
    end

endmodule

// File: rtl/coeff_loader.sv
// rtl/coeff_loader.sv - framed coefficient stream loader driving a tap bank
module coeff_loader
    import coeff_loader_pkg::*;
#(
    parameter int NUM_TAPS    = 8,
    parameter int COEFF_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_load,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [COEFF_WIDTH-1:0]          cfg_data,
    input  logic                            cfg_last,
    input  logic                            run_en,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff_bus,
    output logic [NUM_TAPS-1:0]             tap_enable,
    output logic                            load_done,
    output logic                            load_error,
    output logic                            busy,
    output logic [CNT_WIDTH-1:0]            commit_count
);

    localparam int INDEX_WIDTH = index_width(NUM_TAPS);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_TAPS - 1);

    loader_state_t          state;
    logic [INDEX_WIDTH-1:0] index;
    logic                   bank_valid;
    logic                   beat_we;
    logic                   enable_next;

    assign cfg_ready = (state == LD_LOAD);
    assign busy      = (state == LD_LOAD) || (state == LD_COMMIT);
    // A restart pulse wins over a beat presented in the same cycle.
    assign beat_we   = (state == LD_LOAD) && cfg_valid && !start_load;
    // Looking through COMMIT lets the first enable line up with the first coefficients.
    assign enable_next = run_en && (bank_valid || (state == LD_COMMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LD_IDLE;
            index        <= '0;
            bank_valid   <= 1'b0;
            tap_enable   <= '0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            commit_count <= '0;
        end else begin
            load_done  <= 1'b0;
            tap_enable <= {NUM_TAPS{enable_next}};
            case (state)
                LD_IDLE, LD_ERROR: begin
                    if (start_load) begin
                        state      <= LD_LOAD;
                        index      <= '0;
                        load_error <= 1'b0;
                    end
                end
                LD_LOAD: begin
                    if (start_load) begin
                        index <= '0;
                    end else if (cfg_valid) begin
                        if (index == LAST_INDEX) begin
                            state      <= cfg_last ? LD_COMMIT : LD_ERROR;
                            load_error <= !cfg_last;
                        end else if (cfg_last) begin
                            state      <= LD_ERROR;
                            load_error <= 1'b1;
                        end else begin
                            index <= index + INDEX_WIDTH'(1);
                        end
                    end
                end
                LD_COMMIT: begin
                    state        <= LD_IDLE;
                    bank_valid   <= 1'b1;
                    load_done    <= 1'b1;
                    commit_count <= commit_count + CNT_WIDTH'(1);
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

    coeff_bank #(
        .NUM_TAPS    (NUM_TAPS),
        .COEFF_WIDTH (COEFF_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (beat_we),
        .index     (index),
        .data      (cfg_data),
        .commit    (state == LD_COMMIT),
        .coeff_bus (coeff_bus)
    );

endmodule

// File: tb/tb_coeff_loader.sv
// tb/tb_coeff_loader.sv - randomized self-checking bench for coeff_loader
module tb_coeff_loader;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_load;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [W-1:0]   cfg_data;
    logic           cfg_last;
    logic           run_en;
    logic [N*W-1:0] coeff_bus;
    logic [N-1:0]   tap_enable;
    logic           load_done;
    logic           load_error;
    logic           busy;
    logic [CW-1:0]  commit_count;

    coeff_loader #(.NUM_TAPS(N), .COEFF_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_load   (start_load),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .cfg_last     (cfg_last),
        .run_en       (run_en),
        .coeff_bus    (coeff_bus),
        .tap_enable   (tap_enable),
        .load_done    (load_done),
        .load_error   (load_error),
        .busy         (busy),
        .commit_count (commit_count)
    );

    always #5 clk = ~clk;

    // Reference model: what the taps should currently see.
    logic [N*W-1:0] exp_bus;
    bit             exp_valid;
    int             exp_count;
    bit             exp_err;
    logic [W-1:0]   beat_data [N+2];
    int             tests;
    int             fails;

    function automatic int frame_outcome(input int n, input int last_at);
        if (last_at >= 0 && last_at < N - 1 && last_at < n) return 2;
        if (n >= N) return (last_at == N - 1) ? 1 : 2;
        return 0;
    endfunction

    task automatic model_reset();
        exp_bus   = '0;
        exp_valid = 1'b0;
        exp_count = 0;
        exp_err   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start_load = 1'b0; cfg_valid = 1'b0;
        cfg_data = '0; cfg_last = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input bit last, input bit gap);
        if (gap) begin
            cfg_valid = 1'b0;
            cfg_data  = W'($urandom);
            @(negedge clk);
        end
        cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_last = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N + 2; i++) beat_data[i] = W'($urandom);
    endtask

    // One framed load; checks timing of the commit pulse and the atomic bank update.
    task automatic run_load(input string tag, input int n, input int last_at,
                            input bit gaps, input bit restart);
        int outcome;
        int nb;
        outcome = frame_outcome(n, last_at);
        nb = (outcome == 2 && last_at >= 0 && last_at < N - 1) ? last_at + 1 : N;
        pulse_start();
        exp_err = 1'b0;
        if (restart) begin
            for (int j = 0; j < 3; j++) send_beat(W'($urandom), 1'b0, gaps);
            start_load = 1'b1; cfg_valid = 1'b1; cfg_last = 1'b1; cfg_data = W'($urandom);
            @(negedge clk);
            start_load = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0;
        end
        for (int b = 0; b < nb; b++)
            send_beat(beat_data[b], b == last_at, gaps && ($urandom_range(1) == 1));
        if (outcome == 2) exp_err = 1'b1;
        tests++;
        if (load_done !== 1'b0 || coeff_bus !== exp_bus || load_error !== exp_err) begin
            fails++;
            $display("FAIL %s_k1 done=%b err=%b bus=%h required done=0 err=%b bus=%h",
                     tag, load_done, load_error, coeff_bus, exp_err, exp_bus);
        end
        @(negedge clk);
        if (outcome == 1) begin
            for (int i = 0; i < N; i++) exp_bus[i*W +: W] = beat_data[i];
            exp_valid = 1'b1;
            exp_count = (exp_count + 1) % (1 << CW);
        end
        tests++;
        if (load_done !== (outcome == 1) || coeff_bus !== exp_bus ||
            commit_count !== CW'(exp_count) || tap_enable !== {N{run_en & exp_valid}}) begin
            fails++;
            $display("FAIL %s_k2 done=%b bus=%h cnt=%0d en=%h required done=%b bus=%h cnt=%0d en=%h",
                     tag, load_done, coeff_bus, commit_count, tap_enable, outcome == 1,
                     exp_bus, exp_count, {N{run_en & exp_valid}});
        end
        @(negedge clk);
        tests++;
        if (load_done !== 1'b0 || cfg_ready !== 1'b0 || busy !== 1'b0 || load_error !== exp_err) begin
            fails++;
            $display("FAIL %s_k3 done=%b rdy=%b busy=%b err=%b required 0 0 0 %b",
                     tag, load_done, cfg_ready, busy, load_error, exp_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (coeff_bus !== '0 || tap_enable !== '0 || load_done !== 1'b0 || load_error !== 1'b0 ||
            busy !== 1'b0 || cfg_ready !== 1'b0 || commit_count !== '0) begin
            fails++;
            $display("FAIL reset bus=%h en=%h done=%b err=%b busy=%b rdy=%b cnt=%0d required all 0",
                     coeff_bus, tap_enable, load_done, load_error, busy, cfg_ready, commit_count);
        end
    endtask

    task automatic test_no_commit_enable();
        run_en = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (tap_enable !== '0) begin
            fails++;
            $display("FAIL pre_commit_enable en=%h required 00", tap_enable);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < N; i++) beat_data[i] = W'(16'h0100 * (i + 1));
        run_load("basic", N, N - 1, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            tests++;
            if (coeff_bus[i*W +: W] !== W'(16'h0100 * (i + 1))) begin
                fails++;
                $display("FAIL basic_tap%0d got=%h required=%h", i, coeff_bus[i*W +: W],
                         16'h0100 * (i + 1));
            end
        end
        tests++;
        if (tap_enable !== 8'hFF || commit_count !== CW'(1)) begin
            fails++;
            $display("FAIL basic_en_cnt en=%h cnt=%0d required ff 1", tap_enable, commit_count);
        end
        run_en = 1'b0;
        @(negedge clk);
        tests++;
        if (tap_enable !== 8'h00) begin
            fails++;
            $display("FAIL run_en_drop en=%h required 00", tap_enable);
        end
        run_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_short();
        fill_random();
        run_load("short", N, 4, 1'b0, 1'b0);
        pulse_start();
        tests++;
        if (load_error !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL short_clear err=%b rdy=%b busy=%b required 0 1 1",
                     load_error, cfg_ready, busy);
        end
        fill_random();
        run_load("after_short", N, N - 1, 1'b0, 1'b0);
    endtask

    task automatic test_long();
        fill_random();
        run_load("long", N, -1, 1'b0, 1'b0);
        tests++;
        if (tap_enable !== 8'hFF) begin
            fails++;
            $display("FAIL long_enable en=%h required ff", tap_enable);
        end
    endtask

    task automatic test_restart();
        fill_random();
        run_load("restart", N, N - 1, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int kind;
            fill_random();
            kind = $urandom_range(2);
            run_en = ($urandom_range(3) != 0);
            if (kind == 0) run_load("rand_good", N, N - 1, $urandom_range(1) == 1, 1'b0);
            else if (kind == 1) run_load("rand_short", N, $urandom_range(N - 2), 1'b1, 1'b0);
            else run_load("rand_long", N + 1, N, 1'b0, 1'b0);
        end
        run_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_midload();
        pulse_start();
        for (int j = 0; j < 3; j++) send_beat(W'($urandom), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (coeff_bus !== '0 || tap_enable !== '0 || load_done !== 1'b0 || load_error !== 1'b0 ||
            busy !== 1'b0 || cfg_ready !== 1'b0 || commit_count !== '0) begin
            fails++;
            $display("FAIL async_reset bus=%h en=%h err=%b busy=%b rdy=%b cnt=%0d required all 0",
                     coeff_bus, tap_enable, load_error, busy, cfg_ready, commit_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (tap_enable !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset en=%h busy=%b required 00 0", tap_enable, busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            fill_random();
            run_load("wrap", N, N - 1, 1'b0, 1'b0);
        end
        tests++;
        if (commit_count !== CW'(0)) begin
            fails++;
            $display("FAIL wrap_count cnt=%0d required 0", commit_count);
        end
    endtask

    initial begin
        tests = 0; fails = 0; run_en = 1'b0;
        model_reset();
        test_reset();
        test_no_commit_enable();
        test_basic();
        test_short();
        test_long();
        test_restart();
        test_random();
        test_reset_midload();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
